scoreboard_display: RTL



---
 rtl/scoreboard_pkg.sv | 48 ++++
 rtl/bin2bcd_serial.sv | 55 +++++
 rtl/scoreboard_display.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the seven-segment scoreboard: digit codes,
// digit positions, segment patterns and the conversion FSM states.
package scoreboard_pkg;

  typedef logic [3:0] digit_t;
  localparam digit_t BLANK = 4'hF;

  localparam int BLUE_T = 7;
  localparam int BLUE_U = 6;
  localparam int SEP    = 5;
  localparam int TIME_H = 4;
  localparam int TIME_T = 3;
  localparam int TIME_U = 2;
  localparam int RED_T  = 1;
  localparam int RED_U  = 0;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is never lit, codes 10..15 are dark.
  function automatic logic [7:0] seg_decode(digit_t d);
    case (d)
      4'd0:    return {1'b0, SEG_0};
      4'd1:    return {1'b0, SEG_1};
      4'd2:    return {1'b0, SEG_2};
      4'd3:    return {1'b0, SEG_3};
      4'd4:    return {1'b0, SEG_4};
      4'd5:    return {1'b0, SEG_5};
      4'd6:    return {1'b0, SEG_6};
      4'd7:    return {1'b0, SEG_7};
      4'd8:    return {1'b0, SEG_8};
      4'd9:    return {1'b0, SEG_9};
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: 8-bit binary to 3-digit BCD, one shift per
// clock; the start cycle performs the first shift so done follows 8 shifts.
module bin2bcd_serial (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_bin,
  output logic [11:0] o_bcd,
  output logic        o_done
);

  logic [19:0] r_sr;
  logic [2:0]  r_cnt;
  logic        r_active;
  logic        r_done;

  // Add-3 on every BCD nibble >= 5, then shift the whole {bcd,bin} register.
  function automatic logic [19:0] dabble(logic [19:0] sr);
    logic [19:0] v;
    v = sr;
    for (int i = 0; i < 3; i++) begin
      if (v[8+4*i +: 4] >= 4'd5) v[8+4*i +: 4] = v[8+4*i +: 4] + 4'd3;
    end
    return {v[18:0], 1'b0};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 3'd0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_cnt    <= 3'd1;
        r_active <= 1'b1;
      end else if (r_active) begin
        r_cnt <= r_cnt + 3'd1;
        if (r_cnt == 3'd7) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_start)       r_sr <= dabble({12'd0, i_bin});
    else if (r_active) r_sr <= dabble(r_sr);
  end

  assign o_bcd  = r_sr[19:8];
  assign o_done = r_done;

endmodule

// File: rtl/scoreboard_display.sv
// 8-digit multiplexed scoreboard: B B _ T T T R R. Inputs are converted to BCD
// serially and all digits are committed together so a frame is never torn.
module scoreboard_display
  import scoreboard_pkg::*;
#(
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLINK_CYCLES   = 25000000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] time_left,
  input  logic [6:0] blue_score,
  input  logic [6:0] red_score,
  input  logic       game_over,
  output logic [7:0] seg,
  output logic [7:0] an,
  output logic       busy
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_pending;
  logic [7:0]  r_sh_time;
  logic [6:0]  r_sh_blue;
  logic [6:0]  r_sh_red;
  logic [1:0]  r_op_idx;
  logic [11:0] r_bcd_time;
  logic [11:0] r_bcd_blue;
  logic [11:0] r_bcd_red;
  digit_t      r_digit [8];
  logic [RW-1:0] r_refresh;
  logic [2:0]  r_scan_idx;
  logic [BW-1:0] r_blink_cnt;
  logic        r_blink;
  logic [7:0]  r_seg;
  logic [7:0]  r_an;

  logic        w_change;
  logic        w_snap;
  logic        w_start;
  logic        w_done;
  logic [7:0]  w_operand;
  logic [11:0] w_bcd;
  logic [7:0]  w_blue_fmt;
  logic [7:0]  w_red_fmt;
  logic [11:0] w_time_fmt;
  digit_t      w_code;
  logic [7:0]  w_seg_on;
  logic [7:0]  w_an_on;

  // Scores above 99 saturate to 99; a zero tens digit is blanked.
  function automatic logic [7:0] sat_score(logic [11:0] bcd);
    if (bcd[11:8] != 4'd0) return {4'd9, 4'd9};
    return {((bcd[7:4] == 4'd0) ? BLANK : bcd[7:4]), bcd[3:0]};
  endfunction

  // Leading-zero suppression on hundreds and tens; units always shown.
  function automatic logic [11:0] fmt_time(logic [11:0] bcd);
    digit_t h;
    digit_t t;
    h = (bcd[11:8] == 4'd0) ? BLANK : bcd[11:8];
    t = (bcd[11:4] == 8'd0) ? BLANK : bcd[7:4];
    return {h, t, bcd[3:0]};
  endfunction

  assign w_change = (time_left != r_sh_time) || (blue_score != r_sh_blue) ||
                    (red_score != r_sh_red);
  assign w_snap   = (r_state == IDLE) && (r_pending || w_change);
  assign busy     = (r_state != IDLE);

  always_comb begin
    case (r_op_idx)
      2'd0:    w_operand = r_sh_time;
      2'd1:    w_operand = {1'b0, r_sh_blue};
      default: w_operand = {1'b0, r_sh_red};
    endcase
  end

  bin2bcd_serial u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (w_operand),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    case (r_state)
      IDLE:    if (r_pending || w_change) w_state_nx = LOAD;
      LOAD: begin
        w_start    = 1'b1;
        w_state_nx = SHIFT;
      end
      SHIFT:   if (w_done) w_state_nx = (r_op_idx == 2'd2) ? COMMIT : LOAD;
      COMMIT:  w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Stage p0: change detect, snapshot and conversion sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b1;
      r_sh_time <= 8'd0;
      r_sh_blue <= 7'd0;
      r_sh_red  <= 7'd0;
      r_op_idx  <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      if (w_snap) begin
        r_pending <= 1'b0;
        r_sh_time <= time_left;
        r_sh_blue <= blue_score;
        r_sh_red  <= red_score;
        r_op_idx  <= 2'd0;
      end else begin
        if (w_change) r_pending <= 1'b1;
        if (r_state == SHIFT && w_done) r_op_idx <= r_op_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == SHIFT && w_done) begin
      case (r_op_idx)
        2'd0:    r_bcd_time <= w_bcd;
        2'd1:    r_bcd_blue <= w_bcd;
        default: r_bcd_red  <= w_bcd;
      endcase
    end
  end

  assign w_blue_fmt = sat_score(r_bcd_blue);
  assign w_red_fmt  = sat_score(r_bcd_red);
  assign w_time_fmt = fmt_time(r_bcd_time);

  // Stage p1: atomic digit commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_digit[i] <= BLANK;
    end else if (r_state == COMMIT) begin
      r_digit[BLUE_T] <= w_blue_fmt[7:4];
      r_digit[BLUE_U] <= w_blue_fmt[3:0];
      r_digit[SEP]    <= BLANK;
      r_digit[TIME_H] <= w_time_fmt[11:8];
      r_digit[TIME_T] <= w_time_fmt[7:4];
      r_digit[TIME_U] <= w_time_fmt[3:0];
      r_digit[RED_T]  <= w_red_fmt[7:4];
      r_digit[RED_U]  <= w_red_fmt[3:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_refresh  <= '0;
      r_scan_idx <= 3'd7;
    end else if (r_refresh == RW'(REFRESH_CYCLES - 1)) begin
      r_refresh  <= '0;
      r_scan_idx <= r_scan_idx - 3'd1;
    end else begin
      r_refresh <= r_refresh + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (!game_over) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  // Gating with game_over lets the time digits reappear as soon as it drops.
  always_comb begin
    w_code = r_digit[r_scan_idx];
    if (r_blink && game_over && (r_scan_idx <= 3'(TIME_H)) && (r_scan_idx >= 3'(TIME_U)))
      w_code = BLANK;
    w_seg_on = seg_decode(w_code);
    w_an_on  = 8'b1 << r_scan_idx;
  end

  // Stage p2: registered segment and anode drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_on : w_seg_on;
      r_an  <= (AN_ACTIVE_LOW != 0) ? ~w_an_on : w_an_on;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule
